// File: rtl/ifstage_pipe.sv
// ifstage_pipe: decoupled instruction fetch with PC, 1-cycle IMEM interface, FIFO buffer and PC-relative redirect
module ifstage_pipe #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int IMEM_AW = 10,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int BUF_DEPTH = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Fetch_En,
  input  logic              Redirect,
  input  logic [ADDR_W-1:0] Redirect_Base,
  input  logic [ADDR_W-1:0] Redirect_Immed,
  output logic [IMEM_AW-1:0] Imem_Addr,
  output logic              Imem_Rd,
  input  logic [DATA_W-1:0] Imem_Dout,
  output logic [DATA_W-1:0] Instr,
  output logic [ADDR_W-1:0] Instr_PC,
  output logic              Instr_Valid,
  input  logic              Instr_Ready
);
  localparam int PW = BUF_DEPTH > 1 ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);
  logic [ADDR_W-1:0] pc, infl_pc, target;
  logic infl, pop, push;
  logic [DATA_W-1:0] buf_d [BUF_DEPTH];
  logic [ADDR_W-1:0] buf_pc [BUF_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [CW:0] occ;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(BUF_DEPTH - 1) ? '0 : p + PW'(1);
  endfunction
  // a redirect voids both the consumer handshake and the returning read
  always_comb begin
    Instr_Valid = count != '0;
    pop = Instr_Valid & Instr_Ready & ~Redirect;
    push = infl & ~Redirect;
    occ = {1'b0, count} + (CW+1)'(infl);
    Imem_Rd = ~Reset & Fetch_En & ~Redirect
            & (occ < (CW+1)'(BUF_DEPTH) + (CW+1)'(Instr_Valid & Instr_Ready));
    Imem_Addr = pc[IMEM_AW+1:2];
    target = (Redirect_Base + ADDR_W'(4) + Redirect_Immed) & ~ADDR_W'(3);
    Instr = Instr_Valid ? buf_d[rd_ptr] : '0;
    Instr_PC = Instr_Valid ? buf_pc[rd_ptr] : '0;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc <= RESET_PC;
      infl <= 1'b0;
      infl_pc <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else if (Redirect) begin
      pc <= target;
      infl <= 1'b0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      infl <= Imem_Rd;
      if (Imem_Rd) begin
        pc <= pc + ADDR_W'(4);
        infl_pc <= pc;
      end
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop) rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge Clk) begin
    if (push) begin
      buf_d[wr_ptr] <= Imem_Dout;
      buf_pc[wr_ptr] <= infl_pc;
    end
  end
endmodule

// File: tb/tb_ifstage_pipe.sv
// tb_ifstage_pipe: random and directed stimulus checked against a queue-based fetch model
module tb_ifstage_pipe;
  localparam int DEPTH = 2;
  localparam logic [31:0] RPC = 32'h100;
  logic Clk, Reset, Fetch_En, Redirect, Imem_Rd, Instr_Valid, Instr_Ready;
  logic [31:0] Redirect_Base, Redirect_Immed, Imem_Dout, Instr, Instr_PC;
  logic [9:0] Imem_Addr;
  int n_chk, n_fail;
  typedef struct { logic [31:0] pc; logic [31:0] d; } ent_t;
  ent_t q[$];
  logic [31:0] mpc, mipc;
  bit minf;

  ifstage_pipe #(.ADDR_W(32), .DATA_W(32), .IMEM_AW(10), .RESET_PC(RPC), .BUF_DEPTH(DEPTH)) dut (
    .Clk(Clk), .Reset(Reset), .Fetch_En(Fetch_En), .Redirect(Redirect),
    .Redirect_Base(Redirect_Base), .Redirect_Immed(Redirect_Immed),
    .Imem_Addr(Imem_Addr), .Imem_Rd(Imem_Rd), .Imem_Dout(Imem_Dout),
    .Instr(Instr), .Instr_PC(Instr_PC), .Instr_Valid(Instr_Valid), .Instr_Ready(Instr_Ready)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // IMEM where word k holds the value k
  always @(posedge Clk) if (Imem_Rd) Imem_Dout <= {22'b0, Imem_Addr};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mpc = RPC;
    minf = 0;
    mipc = '0;
  endtask

  task automatic step();
    bit v, p, erd;
    @(negedge Clk);
    v = q.size() != 0;
    p = v && Instr_Ready;
    erd = !Reset && Fetch_En && !Redirect && (int'(q.size()) + int'(minf) - int'(p) < DEPTH);
    chk("valid", 64'(Instr_Valid), 64'(v));
    chk("instr", 64'(Instr), v ? 64'(q[0].d) : 64'd0);
    chk("instr_pc", 64'(Instr_PC), v ? 64'(q[0].pc) : 64'd0);
    chk("imem_rd", 64'(Imem_Rd), 64'(erd));
    chk("imem_addr", 64'(Imem_Addr), 64'(mpc[11:2]));
    if (Reset) model_reset();
    else if (Redirect) begin
      q.delete();
      mpc = (Redirect_Base + 32'd4 + Redirect_Immed) & ~32'd3;
      minf = 0;
    end else begin
      if (p) void'(q.pop_front());
      if (minf) q.push_back('{pc: mipc, d: {22'b0, mipc[11:2]}});
      if (erd) begin
        mipc = mpc;
        mpc = mpc + 32'd4;
      end
      minf = erd;
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic redir(input logic [31:0] b, input logic [31:0] i);
    Redirect = 1; Redirect_Base = b; Redirect_Immed = i;
    step();
    Redirect = 0;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    Reset = 1; Fetch_En = 0; Redirect = 0; Redirect_Base = '0; Redirect_Immed = '0; Instr_Ready = 0;
    repeat (2) @(posedge Clk);
    #1;
    model_reset();
    chk("rst_valid", 64'(Instr_Valid), 64'd0);
    chk("rst_instr", 64'(Instr), 64'd0);
    chk("rst_pc", 64'(Instr_PC), 64'd0);
    chk("rst_rd", 64'(Imem_Rd), 64'd0);
    step();
    Reset = 0; Fetch_En = 1; Instr_Ready = 1;
    repeat (2) step();
    chk("lat_valid", 64'(Instr_Valid), 64'd1);
    chk("lat_pc", 64'(Instr_PC), 64'h100);
    chk("lat_instr", 64'(Instr), 64'h40);
    repeat (4) step();
    Instr_Ready = 0;
    repeat (5) step();
    chk("full_rd", 64'(Imem_Rd), 64'd0);
    Instr_Ready = 1;
    repeat (4) step();
    redir(32'h8, 32'h20);
    repeat (2) step();
    chk("redir_valid", 64'(Instr_Valid), 64'd1);
    chk("redir_pc", 64'(Instr_PC), 64'h2C);
    step();
    redir(32'h40, 32'hFFFF_FFF0);
    chk("neg_addr", 64'(Imem_Addr), 64'hD);
    repeat (3) step();
    redir(32'hFFFF_FFFC, 32'h0);
    chk("wrap_addr", 64'(Imem_Addr), 64'h0);
    repeat (3) step();
    Fetch_En = 0;
    repeat (5) step();
    Fetch_En = 1;
    repeat (2) step();
    redir(32'h200, 32'h10);
    redir(32'h300, 32'h20);
    repeat (4) step();
    Instr_Ready = 0;
    repeat (4) step();
    Reset = 1;
    step();
    chk("mrst_valid", 64'(Instr_Valid), 64'd0);
    chk("mrst_addr", 64'(Imem_Addr), 64'h40);
    Reset = 0; Instr_Ready = 1;
    repeat (4) step();
    for (int c = 0; c < 3000; c++) begin
      Reset = $urandom_range(0, 199) == 0;
      Fetch_En = $urandom_range(0, 9) < 8;
      Instr_Ready = $urandom_range(0, 9) < 6;
      Redirect = $urandom_range(0, 19) == 0;
      Redirect_Base = $urandom;
      Redirect_Immed = $urandom_range(0, 1) ? $urandom : 32'($signed($urandom_range(0, 255)) - 128);
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ifstage_pipe.md
Name: ifstage_pipe

Overview:
- Parametrised, decoupled instruction-fetch stage for the next-generation datapath.
- Holds the PC and drives a synchronous instruction memory with 1-cycle read latency.
- Buffers fetched words in a small FIFO and presents them downstream with a valid/ready handshake.
- Supports PC-relative redirect with flush of the buffer and of any in-flight fetch, plus a fetch enable.

Parameters:
ADDR_W, 32, PC width in bits (≥ IMEM_AW+2)
DATA_W, 32, instruction width
IMEM_AW, 10, instruction-memory word-address width
RESET_PC, 0, PC value loaded on reset (bits [1:0] must be 0)
BUF_DEPTH, 2, fetch-buffer entries (≥ 2)

Ports:
Clk  in  1  clock, all state updates on rising edge
Reset  in  1  synchronous, active-high
Fetch_En  in  1  1 = new fetches may be issued
Redirect  in  1  1 = take branch this cycle
Redirect_Base  in  ADDR_W  PC of the branching instruction
Redirect_Immed  in  ADDR_W  byte offset, two's complement
Imem_Addr  out  IMEM_AW  word address to IMEM
Imem_Rd  out  1  read strobe; data returns next cycle
Imem_Dout  in  DATA_W  IMEM read data, valid the cycle after Imem_Rd
Instr  out  DATA_W  buffer head instruction
Instr_PC  out  ADDR_W  PC of Instr
Instr_Valid  out  1  buffer non-empty
Instr_Ready  in  1  consumer accepts head

Behaviour:
- Reset (sampled on Clk edge) has priority over everything:
  - PC←RESET_PC; buffer empty; in-flight flag cleared.
  - Instr_Valid=0, Imem_Rd=0, Instr=0, Instr_PC=0.
  - Reset asserted mid-operation discards all buffered and in-flight data.
- Issue condition (combinational): Imem_Rd = Fetch_En & ~Redirect & (count + inflight − pop < BUF_DEPTH).
  - pop = Instr_Valid & Instr_Ready.
  - count = buffer occupancy; inflight = 1 if a read was issued last cycle and not killed.
- Address: Imem_Addr = PC[IMEM_AW+1:2]. On issue, PC←PC+4 (modulo 2^ADDR_W, wraps silently), and the issued PC is latched with the in-flight flag.
- Response:
  - The cycle after an unkilled issue, Imem_Dout and its latched PC are written to the buffer tail.
  - Instr_Valid rises the following cycle.
  - Reset-to-first-Instr_Valid = 2 cycles when Fetch_En=1.
- Throughput: with Instr_Ready held 1, one instruction per cycle is sustained after the initial 2-cycle latency. Buffer never overflows; the issue condition guarantees a slot.
- Simultaneous push and pop on the same edge: count unchanged, data order preserved. Pop on empty is impossible (Instr_Valid=0).
- Head stability: Instr/Instr_PC stay stable while Instr_Valid=1 & Instr_Ready=0.
- Redirect (priority over issue, push and pop):
  - Target = (Redirect_Base + 4 + Redirect_Immed) with bits [1:0] forced to 00, mod 2^ADDR_W.
  - On the edge: PC←target, buffer cleared, in-flight response killed (its data is never written).
  - No issue occurs in the Redirect cycle.
  - The handshake in a Redirect cycle is void: the consumer discards that transfer, and the block does not count it as a pop.
  - Target issued the cycle after Redirect (if Fetch_En); Instr_Valid with Instr_PC=target 3 cycles after the Redirect cycle.
  - Back-to-back Redirects: the last one wins.
- Fetch_En=0:
  - No new issue; PC holds.
  - An outstanding read still completes into the buffer.
  - Buffered entries still drain.
- Outputs Instr/Instr_PC/Instr_Valid are registered (buffer head); no combinational path from Instr_Ready to them. Imem_Rd/Imem_Addr depend combinationally on Instr_Ready, Redirect and Fetch_En only.

Test Plan:
- Reset then Fetch_En=1, Instr_Ready=1, IMEM word k = k → Instr_Valid high from cycle 2; Instr/Instr_PC = 0/0x0, 1/0x4, 2/0x8 on consecutive cycles, no bubbles.
- Instr_Ready=0 for 5 cycles with BUF_DEPTH=2 → exactly 2 entries buffered, Imem_Rd=0 while full; on release, PCs 0x0, 0x4, 0x8 delivered in order, no loss or duplicate.
- Redirect at PC 0x10 with Redirect_Base=0x8, Redirect_Immed=0x20 → buffer flushed, the killed in-flight word is never seen; next valid Instr_PC=0x2C, 3 cycles after the Redirect cycle.
- Redirect_Immed=0xFFFFFFF0 (−16) with Base=0x40 → target 0x34; Base=0xFFFFFFFC, Immed=0 → PC wraps to 0x0.
- Fetch_En dropped with one read outstanding → that word still appears; no further Imem_Rd; PC frozen until Fetch_En=1.
- Reset asserted mid-stream with a full buffer → next cycle Instr_Valid=0; fetch restarts at RESET_PC (test with RESET_PC=0x100, Imem_Addr=0x40).
